axis_linear_interp: RTL and testbench

- Upsampling counterpart of the boxcar FIR decimator in the RPSPMC AXIS datapath.
- Accepts low-rate samples on S_AXIS and emits a linearly interpolated stream on M_AXIS, one output per next_dv strobe.
- Each input segment spans 2^INTERP_L output steps.
- Feeds high-rate consumers such as DAC/bias paths from decimated, slow control values.

---
 rtl/rpspmc_axis_pkg.sv | 19 +
 rtl/axis_skid_slot.sv | 47 ++++
 rtl/axis_linear_interp.sv | 143 ++++++++++++++
 tb/tb_axis_linear_interp.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpspmc_axis_pkg.sv
// Shared types and width helpers for the RPSPMC AXIS rate-conversion blocks.
package rpspmc_axis_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } interp_state_e;

    // Accumulator holds value<<L, so it needs L extra bits.
    function automatic int unsigned acc_width(input int unsigned s_w, input int unsigned l);
        return s_w + l;
    endfunction

    function automatic int unsigned delta_width(input int unsigned s_w);
        return s_w + 1;
    endfunction

endpackage

// File: rtl/axis_skid_slot.sv
// One-entry pending register; a consume in the same cycle frees the slot for a new write.
module axis_skid_slot #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_valid_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             store_en_i,
    input  logic             consume_i,
    output logic             ready_o,
    output logic             pend_valid_o,
    output logic [Width-1:0] pend_data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;
    logic             wr;

    assign ready_o      = !valid_q || consume_i;
    assign pend_valid_o = valid_q;
    assign pend_data_o  = data_q;

    always_comb begin
        wr      = wr_valid_i && ready_o && store_en_i;
        valid_d = valid_q;
        data_d  = data_q;
        if (consume_i) begin
            valid_d = 1'b0;
        end
        if (wr) begin
            valid_d = 1'b1;
            data_d  = wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/axis_linear_interp.sv
// Linear-interpolating upsampler: each input segment is stepped over 2^INTERP_L next_dv strobes.
module axis_linear_interp
    import rpspmc_axis_pkg::*;
#(
    parameter int unsigned SAXIS_TDATA_WIDTH = 32,
    parameter int unsigned MAXIS_TDATA_WIDTH = 32,
    parameter int unsigned INTERP_L          = 6,
    parameter int unsigned UNDERRUN_W        = 16
) (
    input  logic                         a_clk,
    input  logic                         a_reset,
    input  logic                         next_dv,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                         S_AXIS_tvalid,
    output logic                         S_AXIS_tready,
    output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                         M_AXIS_tvalid,
    output logic [UNDERRUN_W-1:0]        underrun_count
);

    localparam int unsigned SW     = SAXIS_TDATA_WIDTH;
    localparam int unsigned MW     = MAXIS_TDATA_WIDTH;
    localparam int unsigned AccW   = acc_width(SW, INTERP_L);
    localparam int unsigned DeltaW = delta_width(SW);

    interp_state_e             state_q, state_d;
    logic signed [AccW-1:0]    acc_q, acc_d, acc_sum;
    logic signed [DeltaW-1:0]  delta_q, delta_d, delta_load;
    logic signed [SW-1:0]      cur_q, cur_d;
    logic [INTERP_L-1:0]       step_q, step_d;
    logic [UNDERRUN_W-1:0]     underrun_q, underrun_d;
    logic [MW-1:0]             tdata_q, tdata_d;
    logic                      tvalid_q, tvalid_d;
    logic                      consume;
    logic                      store_en;
    logic                      pend_valid;
    logic [SW-1:0]             pend_data;

    // In IDLE the first sample loads the accumulator directly instead of the slot.
    assign store_en = (state_q != IDLE);

    axis_skid_slot #(
        .Width (SW)
    ) u_slot (
        .clk_i        (a_clk),
        .rst_i        (a_reset),
        .wr_valid_i   (S_AXIS_tvalid),
        .wr_data_i    (S_AXIS_tdata),
        .store_en_i   (store_en),
        .consume_i    (consume),
        .ready_o      (S_AXIS_tready),
        .pend_valid_o (pend_valid),
        .pend_data_o  (pend_data)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        delta_d    = delta_q;
        cur_d      = cur_q;
        step_d     = step_q;
        underrun_d = underrun_q;
        tdata_d    = tdata_q;
        tvalid_d   = 1'b0;
        consume    = 1'b0;
        acc_sum    = acc_q + AccW'(delta_q);
        delta_load = DeltaW'($signed(pend_data)) - DeltaW'(cur_q);

        unique case (state_q)
            IDLE: begin
                if (S_AXIS_tvalid && S_AXIS_tready) begin
                    acc_d   = $signed({S_AXIS_tdata, {INTERP_L{1'b0}}});
                    cur_d   = $signed(S_AXIS_tdata);
                    delta_d = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (next_dv) begin
                    tvalid_d = 1'b1;
                    tdata_d  = acc_q[AccW-1 -: MW];
                    if (pend_valid) begin
                        consume = 1'b1;
                        delta_d = delta_load;
                        cur_d   = $signed(pend_data);
                        step_d  = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (next_dv) begin
                    tvalid_d = 1'b1;
                    acc_d    = acc_sum;
                    step_d   = step_q + INTERP_L'(1);
                    tdata_d  = acc_sum[AccW-1 -: MW];
                    // Last step of the segment: acc now equals cur<<L exactly.
                    if (&step_q) begin
                        if (pend_valid) begin
                            consume = 1'b1;
                            delta_d = delta_load;
                            cur_d   = $signed(pend_data);
                        end else begin
                            delta_d = '0;
                            state_d = HOLD;
                            if (!(&underrun_q)) begin
                                underrun_d = underrun_q + UNDERRUN_W'(1);
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            delta_q    <= '0;
            cur_q      <= '0;
            step_q     <= '0;
            underrun_q <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            delta_q    <= delta_d;
            cur_q      <= cur_d;
            step_q     <= step_d;
            underrun_q <= underrun_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
        end
    end

    assign M_AXIS_tdata   = tdata_q;
    assign M_AXIS_tvalid  = tvalid_q;
    assign underrun_count = underrun_q;

endmodule

// File: tb/tb_axis_linear_interp.sv
// Scoreboard bench: two configurations (L=2/M=32 and L=6/M=16) share one stimulus stream.
module tb_axis_linear_interp;

    logic        clk = 1'b0;
    logic        a_reset = 1'b1;
    logic        next_dv = 1'b0;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;

    logic        rdy0, tv0, rdy1, tv1;
    logic [31:0] td0;
    logic [15:0] td1, und0, und1;

    always #5 clk = ~clk;

    axis_linear_interp #(
        .SAXIS_TDATA_WIDTH (32),
        .MAXIS_TDATA_WIDTH (32),
        .INTERP_L          (2),
        .UNDERRUN_W        (16)
    ) dut0 (
        .a_clk          (clk),
        .a_reset        (a_reset),
        .next_dv        (next_dv),
        .S_AXIS_tdata   (s_tdata),
        .S_AXIS_tvalid  (s_tvalid),
        .S_AXIS_tready  (rdy0),
        .M_AXIS_tdata   (td0),
        .M_AXIS_tvalid  (tv0),
        .underrun_count (und0)
    );

    axis_linear_interp #(
        .SAXIS_TDATA_WIDTH (32),
        .MAXIS_TDATA_WIDTH (16),
        .INTERP_L          (6),
        .UNDERRUN_W        (16)
    ) dut1 (
        .a_clk          (clk),
        .a_reset        (a_reset),
        .next_dv        (next_dv),
        .S_AXIS_tdata   (s_tdata),
        .S_AXIS_tvalid  (s_tvalid),
        .S_AXIS_tready  (rdy1),
        .M_AXIS_tdata   (td1),
        .M_AXIS_tvalid  (tv1),
        .underrun_count (und1)
    );

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    logic [31:0] got0[$];
    logic [15:0] got1[$];

    // Reference model: per-DUT segment endpoints a->b, step k of n, one pending sample.
    int     m_st  [2] = '{0, 0};
    longint m_a   [2] = '{0, 0};
    longint m_b   [2] = '{0, 0};
    int     m_k   [2] = '{0, 0};
    bit     m_pv  [2] = '{0, 0};
    longint m_pd  [2] = '{0, 0};
    int     m_und [2] = '{0, 0};

    int          s1_exp [8] = '{0, 100, 200, 300, 400, 400, 400, 400};
    int          s2_exp [6] = '{400, 200, 0, -200, -400, -400};
    logic [31:0] s3_exp [5] = '{32'h7fffffff, 32'h3fffffff, 32'hffffffff, 32'hbfffffff,
                                32'h80000000};
    logic [31:0] s4_in  [4] = '{32'd0, 32'd4, 32'd8, 32'd12};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int lval(input int d);
        return (d == 0) ? 2 : 6;
    endfunction

    function automatic int mval(input int d);
        return (d == 0) ? 32 : 16;
    endfunction

    // Value at step k of a->b on the output grid: floor((a*N + (b-a)*k) / 2^(S+L-M)).
    function automatic logic [31:0] interp(input int d, input longint a, input longint b,
                                           input int k);
        longint      v;
        logic [63:0] u;
        v = ((a * (longint'(1) << lval(d))) + (b - a) * longint'(k)) >>> (32 + lval(d) - mval(d));
        u = v;
        return (d == 0) ? u[31:0] : {16'h0, u[15:0]};
    endfunction

    task automatic push_exp(input int d, input logic [31:0] v);
        if (d == 0) exp0.push_back(v);
        else exp1.push_back(v);
    endtask

    task automatic model_step(input int d, input logic rdy);
        int     n;
        int     st0;
        bit     pv0;
        bit     cons;
        longint sd;
        n    = 1 << lval(d);
        st0  = m_st[d];
        pv0  = m_pv[d];
        cons = 1'b0;
        sd   = longint'($signed(s_tdata));
        if (a_reset) begin
            m_st[d]  = 0;
            m_pv[d]  = 1'b0;
            m_und[d] = 0;
            return;
        end
        case (m_st[d])
            0: begin
                if (s_tvalid) begin
                    m_b[d]  = sd;
                    m_st[d] = 1;
                end
            end
            1: begin
                if (next_dv) begin
                    push_exp(d, interp(d, m_b[d], m_b[d], 0));
                    if (m_pv[d]) begin
                        cons    = 1'b1;
                        m_a[d]  = m_b[d];
                        m_b[d]  = m_pd[d];
                        m_k[d]  = 0;
                        m_pv[d] = 1'b0;
                        m_st[d] = 2;
                    end
                end
            end
            default: begin
                if (next_dv) begin
                    m_k[d]++;
                    push_exp(d, interp(d, m_a[d], m_b[d], m_k[d]));
                    if (m_k[d] == n) begin
                        if (m_pv[d]) begin
                            cons    = 1'b1;
                            m_a[d]  = m_b[d];
                            m_b[d]  = m_pd[d];
                            m_k[d]  = 0;
                            m_pv[d] = 1'b0;
                        end else begin
                            m_st[d] = 1;
                            if (m_und[d] < 65535) m_und[d]++;
                        end
                    end
                end
            end
        endcase
        chk($sformatf("tready%0d", d), {63'd0, rdy}, {63'd0, (!pv0 || cons)});
        if (st0 != 0 && s_tvalid && rdy) begin
            m_pv[d] = 1'b1;
            m_pd[d] = sd;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rdy0);
        model_step(1, rdy1);
    end

    task automatic mon(input int d, input logic tv, input logic [31:0] td, input logic [15:0] u);
        int          sz;
        logic [31:0] e;
        sz = (d == 0) ? exp0.size() : exp1.size();
        if (sz > 0 || tv) begin
            if (sz == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_out%0d: got tvalid=1 data %0h expected no output", d, td);
            end else begin
                e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
                chk($sformatf("tvalid%0d", d), {63'd0, tv}, 64'd1);
                if (tv) chk($sformatf("tdata%0d", d), {32'd0, td}, {32'd0, e});
            end
        end
        chk($sformatf("underrun%0d", d), {48'd0, u}, 64'(m_und[d]));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, tv0, td0, und0);
            mon(1, tv1, {16'h0, td1}, und1);
            if (tv0) got0.push_back(td0);
            if (tv1) got1.push_back(td1);
        end
    end

    task automatic cyc(input logic dv, input logic tv, input logic [31:0] td, output logic acc);
        @(negedge clk);
        next_dv  = dv;
        s_tvalid = tv;
        s_tdata  = td;
        #1;
        acc = tv && rdy0;
    endtask

    task automatic run(input int n, input logic dv);
        logic a;
        repeat (n) cyc(dv, 1'b0, 32'd0, a);
    endtask

    task automatic send(input logic [31:0] v);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 200 && !a; i++) cyc(1'b0, 1'b1, v, a);
        if (!a) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        a_reset  = 1'b1;
        next_dv  = 1'b0;
        s_tvalid = 1'b0;
        @(negedge clk);
        a_reset = 1'b0;
        #1;
        chk("rst_tvalid0", {63'd0, tv0}, 64'd0);
        chk("rst_tready0", {63'd0, rdy0}, 64'd1);
        chk("rst_underrun0", {48'd0, und0}, 64'd0);
        chk("rst_tvalid1", {63'd0, tv1}, 64'd0);
        chk("rst_tready1", {63'd0, rdy1}, 64'd1);
    endtask

    initial begin
        logic a;
        int   idx;
        int   kk;
        int   base;
        repeat (2) @(negedge clk);
        a_reset = 1'b0;
        mon_en  = 1'b1;

        // Ramp 0 -> 400 then underrun hold.
        do_reset();
        send(32'd0);
        send(32'd400);
        got0.delete();
        run(8, 1'b1);
        run(3, 1'b0);
        chk("s1_len", 64'(got0.size()), 64'd8);
        for (int k = 0; k < 8 && k < got0.size(); k++)
            chk($sformatf("s1_out%0d", k), {32'd0, got0[k]}, {32'd0, 32'(s1_exp[k])});
        chk("s1_underrun", {48'd0, und0}, 64'd1);

        // Descending ramp ends exactly on the endpoint.
        do_reset();
        send(32'd400);
        send(-32'sd400);
        got0.delete();
        run(6, 1'b1);
        run(3, 1'b0);
        chk("s2_len", 64'(got0.size()), 64'd6);
        for (int k = 0; k < 6 && k < got0.size(); k++)
            chk($sformatf("s2_out%0d", k), {32'd0, got0[k]}, {32'd0, 32'(s2_exp[k])});

        // Full-scale swing.
        do_reset();
        send(32'h7fffffff);
        send(32'h80000000);
        got0.delete();
        run(5, 1'b1);
        run(3, 1'b0);
        chk("s3_len", 64'(got0.size()), 64'd5);
        for (int k = 0; k < 5 && k < got0.size(); k++)
            chk($sformatf("s3_out%0d", k), {32'd0, got0[k]}, {32'd0, s3_exp[k]});

        // Back-to-back samples: accept and consume coincide at each segment end.
        do_reset();
        got0.delete();
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            cyc(c >= 1, idx < 4, s4_in[(idx < 4) ? idx : 3], a);
            if (a && idx < 4) idx++;
        end
        run(2, 1'b0);
        chk("s4_len", 64'(got0.size()), 64'd13);
        for (int k = 0; k < 13 && k < got0.size(); k++)
            chk($sformatf("s4_out%0d", k), {32'd0, got0[k]}, 64'((k < 2) ? 0 : k - 1));
        chk("s4_underrun", {48'd0, und0}, 64'd0);
        run(1, 1'b1);
        run(2, 1'b0);
        if (got0.size() > 13) chk("s4_last", {32'd0, got0[13]}, 64'd12);
        else chk("s4_last_missing", 64'(got0.size()), 64'd14);
        chk("s4_underrun_end", {48'd0, und0}, 64'd1);

        // Reset two steps into a ramp.
        do_reset();
        send(32'd0);
        send(32'd400);
        got0.delete();
        run(3, 1'b1);
        do_reset();
        chk("s5_len", 64'(got0.size()), 64'd3);
        run(5, 1'b1);
        run(2, 1'b0);
        chk("s5_no_out", 64'(got0.size()), 64'd3);

        // L=6, M=16 ramp 0 -> 0x10000 against floor division.
        do_reset();
        send(32'd0);
        send(32'h10000);
        got1.delete();
        run(66, 1'b1);
        run(2, 1'b0);
        chk("s6_len", 64'(got1.size()), 64'd66);
        for (int k = 0; k < 66 && k < got1.size(); k++) begin
            kk = (k > 64) ? 64 : k;
            chk($sformatf("s6_out%0d", k), {48'd0, got1[k]},
                64'((longint'(65536) * kk) / longint'(4194304)));
        end

        // Randomized traffic, occasional resets, varying strobe density.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            logic        dv;
            logic        tvr;
            logic [31:0] tdr;
            if ($urandom_range(0, 1499) == 0) do_reset();
            base = ((c / 500) % 2 == 0) ? 4 : 1;
            dv   = ($urandom_range(0, base - 1) == 0);
            tvr  = ($urandom_range(0, 1) == 1);
            tdr  = ($urandom_range(0, 1) == 1) ? $urandom :
                   (32'($urandom_range(0, 4095)) - 32'd2048);
            cyc(dv, tvr, tdr, a);
        end
        run(4, 1'b0);
        chk("drain0", 64'(exp0.size()), 64'd0);
        chk("drain1", 64'(exp1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
